// File: rtl/layer0_sched.sv
// layer0_sched: frame/row sequencer for the layer0 datapath with a row watchdog
// and a shared image-memory read port arbitrated against a secondary requester.
module layer0_sched #(
    parameter int COLS    = 64,
    parameter int ROWS    = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_l0_ready,
    input  logic        i_l0_busy,
    output logic        o_l0_go_down,
    input  logic        i_l0_valid,
    input  logic [11:0] i_l0_addr,
    input  logic        i_ds_ready,
    input  logic        i_l1_req,
    input  logic [11:0] i_l1_addr,
    output logic        o_l1_gnt,
    output logic [11:0] o_mem_addr
);
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, START, ROW, WAITDS, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   col_cnt, col_n;
    logic [RW-1:0]   row_cnt, row_n;
    logic [WW-1:0]   wd, wd_n;
    logic            err_n, go, gnt_n;

    always_comb begin
        state_n = state;
        col_n   = col_cnt;
        row_n   = row_cnt;
        wd_n    = '0;
        err_n   = o_err;
        go      = 1'b0;
        case (state)
            IDLE: if (i_start) begin
                state_n = START;
                err_n   = 1'b0;
                col_n   = '0;
                row_n   = '0;
            end
            START: state_n = ROW;
            ROW: if (i_l0_valid) begin
                if (col_cnt == CW'(COLS - 1)) begin
                    col_n = '0;
                    if (row_cnt == RW'(ROWS - 1)) state_n = DONE;
                    else begin
                        row_n   = row_cnt + 1'b1;
                        state_n = WAITDS;
                    end
                end else col_n = col_cnt + 1'b1;
            end else if (wd == WW'(TIMEOUT - 1)) begin
                err_n   = 1'b1;
                state_n = IDLE;
            end else wd_n = wd + 1'b1;
            WAITDS: if (!i_l0_busy && i_ds_ready && !o_l1_gnt) begin
                go      = 1'b1;
                state_n = ROW;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // a row advance in WAITDS takes priority over a fresh grant request
        gnt_n = o_l1_gnt ? i_l1_req
              : i_l1_req && !go && (state == IDLE || (state == WAITDS && !i_l0_busy));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            col_cnt      <= '0;
            row_cnt      <= '0;
            wd           <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_l0_ready   <= 1'b0;
            o_l0_go_down <= 1'b0;
            o_l1_gnt     <= 1'b0;
        end else begin
            state        <= state_n;
            col_cnt      <= col_n;
            row_cnt      <= row_n;
            wd           <= wd_n;
            o_busy       <= state_n != IDLE;
            o_done       <= state_n == DONE;
            o_err        <= err_n;
            o_l0_ready   <= state_n == START;
            o_l0_go_down <= go;
            o_l1_gnt     <= gnt_n;
        end
    end

    assign o_mem_addr = o_l1_gnt ? i_l1_addr : i_l0_addr;
endmodule

// File: doc/layer0_sched.md
LAYER0_SCHED -- requirements
Module: layer0_sched

Interface
- REQ-001 Parameter COLS, default 64: output pixels per row produced by the layer0 datapath.
- REQ-002 Parameter ROWS, default 64: output rows per frame.
- REQ-003 Parameter TIMEOUT, default 1023: maximum idle cycles in ROW between i_l0_valid pulses.
- REQ-004 clk  input  1  rising-edge clock for all state.
- REQ-005 reset  input  1  asynchronous, active-low reset.
- REQ-006 i_start  input  1  host frame-start pulse.
- REQ-007 o_busy  output  1  high while a frame is in progress (any state except IDLE).
- REQ-008 o_done  output  1  one-cycle pulse on frame completion.
- REQ-009 o_err  output  1  sticky watchdog error; cleared by the next accepted i_start.
- REQ-010 o_l0_ready  output  1  start strobe to the layer0 i_ready.
- REQ-011 i_l0_busy  input  1  layer0 o_busy.
- REQ-012 o_l0_go_down  output  1  next-row strobe to the layer0 i_go_down.
- REQ-013 i_l0_valid  input  1  layer0 output pixel valid.
- REQ-014 i_l0_addr  input  12  layer0 image-memory read address.
- REQ-015 i_ds_ready  input  1  downstream can accept one more output row (level).
- REQ-016 i_l1_req / i_l1_addr  input  1 / 12  secondary requester read request and address.
- REQ-017 o_l1_gnt  output  1  secondary requester owns the memory port.
- REQ-018 o_mem_addr  output  12  shared image-memory read address.

Function
- REQ-019 The FSM SHALL have states IDLE, START, ROW, WAITDS, DONE, with all outputs registered except o_mem_addr.
- REQ-020 IDLE: i_start=1 -> START; clear o_err, row_cnt, col_cnt, and watchdog; i_start SHALL be ignored in every other state.
- REQ-021 START: o_l0_ready=1 for exactly one cycle -> ROW.
- REQ-022 ROW: each i_l0_valid SHALL increment col_cnt; a valid at col_cnt==COLS-1 SHALL set col_cnt=0 and, if row_cnt==ROWS-1 -> DONE, else row_cnt+1 -> WAITDS.
- REQ-023 WAITDS: when i_l0_busy=0, i_ds_ready=1, and o_l1_gnt=0, o_l0_go_down=1 for exactly one cycle -> ROW.
- REQ-024 DONE: o_done=1 for one cycle -> IDLE.
- REQ-025 i_l0_valid outside ROW SHALL be ignored (no counter change).
- REQ-026 Watchdog: in ROW, count cycles since the last valid (reset on valid or ROW entry); reaching TIMEOUT SHALL set o_err=1 and go to IDLE without o_done.
- REQ-027 Arbitration: o_l1_gnt SHALL rise the cycle after i_l1_req=1 is sampled while state is IDLE, or WAITDS with i_l0_busy=0.
- REQ-028 Once high, o_l1_gnt SHALL hold until i_l1_req=0 is sampled, then fall next cycle.
- REQ-029 Simultaneous go_down condition and new i_l1_req in WAITDS with o_l1_gnt=0: go_down SHALL win and grant is not issued.
- REQ-030 o_mem_addr SHALL equal i_l1_addr when o_l1_gnt=1, else i_l0_addr (combinational mux on the registered grant).
- REQ-031 Counters SHALL be $clog2 sized; row_cnt/col_cnt SHALL never exceed ROWS-1/COLS-1.

Reset
- REQ-032 reset=0 SHALL immediately force state=IDLE, all counters 0, and o_busy, o_done, o_err, o_l0_ready, o_l0_go_down, o_l1_gnt = 0, regardless of the operation in progress.
- REQ-033 After reset release, the first rising edge with i_start=1 SHALL start a frame normally.

Verification
- REQ-034 ROWS=2, COLS=4, i_ds_ready=1: pulse i_start, 4 valids, i_l0_busy=0, 4 valids -> o_l0_ready one cycle, o_l0_go_down once, o_done once, o_busy low after.
- REQ-035 i_ds_ready=0 for 10 cycles in WAITDS -> no go_down; ds_ready=1 -> go_down next cycle.
- REQ-036 i_l1_req=1 in IDLE with i_l1_addr=12'h0A5 -> o_l1_gnt=1 next cycle, o_mem_addr=12'h0A5; req=0 -> grant drops next cycle, o_mem_addr=i_l0_addr.
- REQ-037 TIMEOUT=8, no valids in ROW -> o_err=1 after 8 cycles, state IDLE, no o_done; next i_start clears o_err.
- REQ-038 reset=0 asserted mid-ROW with row_cnt=1 -> all outputs 0 asynchronously; a fresh frame then completes with correct counts.
- REQ-039 i_start pulsed during ROW -> ignored, frame completes with exactly one o_done.
